// File: rtl/pulse_stretcher_if.sv
// Bundle of request/status signals between a pulse stretcher and its client.
// The client drives p/ena; the stretcher drives the stretched output and status.
interface pulse_stretcher_if #(
    parameter int QW = 2
);
    // Request protocol: p is a one-clock request that is always accepted;
    // there is no ready/backpressure, so a lost request is reported via ovf.
    logic          ena;
    logic          p;
    logic          k_out;
    logic          busy;
    logic [QW-1:0] pending;
    logic          ovf;
    logic [1:0]    dbg_state;

    modport master (
        output ena,
        output p,
        input  k_out,
        input  busy,
        input  pending,
        input  ovf,
        input  dbg_state
    );

    modport slave (
        input  ena,
        input  p,
        output k_out,
        output busy,
        output pending,
        output ovf,
        output dbg_state
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches one-clock pulses into active-low phases of WIDTH ena ticks plus a GAP-tick gap.
// Define PULSE_QUEUE_EN to queue and replay requests that arrive while a phase is running.
module pulse_stretcher #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2,
    parameter int QW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_stretcher_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAPW   = 2'd2
    } state_t;

    localparam int CMAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] WIDTH_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [QW-1:0] PEND_MAX   = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          k_q, busy_q;

    logic          have_pend;
    logic          phase_end;
    logic          start;
    logic          consume;
    logic          queue_req;

`ifdef PULSE_QUEUE_EN
    assign have_pend = (pending_q != '0);
`else
    assign have_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            k_q       <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            k_q       <= (state_d != ACTIVE);
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        phase_end = 1'b0;
        start     = 1'b0;
        consume   = 1'b0;
        queue_req = 1'b0;

        case (state_q)
            IDLE: begin
                // A request left over from an exit edge takes precedence over a new p.
                if (have_pend) begin
                    start   = 1'b1;
                    consume = 1'b1;
                end else if (bus.p) begin
                    start = 1'b1;
                end
            end
            ACTIVE: begin
                if (bus.ena) begin
                    if (cnt_q == '0) begin
                        if (GAP > 0) begin
                            state_d = GAPW;
                            cnt_d   = GAP_LOAD;
                        end else begin
                            phase_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            GAPW: begin
                if (bus.ena) begin
                    if (cnt_q == '0) begin
                        phase_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (phase_end) begin
            if (have_pend) begin
                start   = 1'b1;
                consume = 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end

        if (start) begin
            state_d = ACTIVE;
            cnt_d   = WIDTH_LOAD;
        end

        // Every p that does not directly start a phase from an empty IDLE is a queued request.
        queue_req = bus.p && !((state_q == IDLE) && !have_pend);

`ifdef PULSE_QUEUE_EN
        if (queue_req && !consume) begin
            if (pending_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + QW'(1);
            end
        end else if (!queue_req && consume) begin
            pending_d = pending_q - QW'(1);
        end
`else
        pending_d = '0;
        if (queue_req) begin
            ovf_d = 1'b1;
        end
`endif
    end

    assign bus.k_out     = k_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (WIDTH=4, GAP=2, QW=2); the queue scenarios
// are selected with PULSE_QUEUE_EN, the drop/overflow scenarios otherwise.
module tb_pulse_stretcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pulse_stretcher_if #(.QW(2)) bus ();

    pulse_stretcher #(
        .WIDTH(4),
        .GAP  (2),
        .QW   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int low_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic k, input logic b,
                           input logic [1:0] pend, input logic o);
        chk({tag, ".k_out"},   bus.k_out,   k);
        chk({tag, ".busy"},    bus.busy,    b);
        chk({tag, ".pending"}, bus.pending, pend);
        chk({tag, ".ovf"},     bus.ovf,     o);
    endtask

    // One clock edge with the given p/ena; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic pv, input logic ev);
        bus.p   = pv;
        bus.ena = ev;
        @(posedge clk);
        #1;
        bus.p = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.p   = 1'b0;
        bus.ena = 1'b1;
        rst_n   = 1'b0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        rst_n = 1'b1;
        chk_out("reset", 1'b1, 1'b0, 2'd0, 1'b0);
        chk("reset.state", bus.dbg_state, 2'd0);

        // Basic stretch: 4 low cycles, 2 gap cycles, then idle.
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("stretch.k_out", bus.k_out, (i >= 4));
            chk("stretch.busy",  bus.busy,  (i < 6));
            cyc(1'b0, 1'b1);
        end

        // ena every 3rd clk; p lands on a non-ena edge at c=1.
        for (int c = 0; c <= 20; c++) begin
            cyc((c == 1), ((c % 3) == 0));
            chk("gate.k_out", bus.k_out, !(c >= 1 && c < 12));
            chk("gate.busy",  bus.busy,  (c >= 1 && c < 18));
        end

        // Counter freeze while ena is held low mid-phase.
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (20) cyc(1'b0, 1'b0);
        chk("freeze.k_out", bus.k_out, 1'b0);
        chk("freeze.state", bus.dbg_state, 2'd1);
        cyc(1'b0, 1'b1);
        chk("freeze.k1", bus.k_out, 1'b0);
        cyc(1'b0, 1'b1);
        chk("freeze.k2", bus.k_out, 1'b0);
        cyc(1'b0, 1'b1);
        chk_out("freeze.gap", 1'b1, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("freeze.gap2", bus.busy, 1'b1);
        cyc(1'b0, 1'b1);
        chk_out("freeze.idle", 1'b1, 1'b0, 2'd0, 1'b0);

`ifdef PULSE_QUEUE_EN
        // Three extra requests during the first low phase -> three replays.
        for (int n = 0; n <= 25; n++) begin
            cyc((n <= 3), 1'b1);
            chk("queue.k_out", bus.k_out, !(((n % 6) <= 3) && (n <= 21)));
            chk("queue.busy",  bus.busy,  (n <= 23));
            chk("queue.pending", bus.pending,
                (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 2 : (n <= 5) ? 3 :
                (n <= 11) ? 2 : (n <= 17) ? 1 : 0);
            chk("queue.ovf", bus.ovf, 1'b0);
        end

        // Four extra requests saturate the queue; only three replays.
        do_reset();
        low_cnt = 0;
        for (int n = 0; n <= 29; n++) begin
            cyc((n <= 4), 1'b1);
            if (!bus.k_out) low_cnt++;
            if (n == 4) chk_out("sat.full", 1'b1, 1'b1, 2'd3, 1'b1);
        end
        chk("sat.low_cycles", low_cnt, 16);
        chk_out("sat.end", 1'b1, 1'b0, 2'd0, 1'b1);
        do_reset();
        chk("sat.ovf_cleared", bus.ovf, 1'b0);

        // p on the gap exit edge while one request is queued.
        for (int n = 0; n <= 19; n++) begin
            cyc((n == 0 || n == 1 || n == 6), 1'b1);
            if (n == 5)  chk_out("simul_gap.n5",  1'b1, 1'b1, 2'd1, 1'b0);
            if (n == 6)  chk_out("simul_gap.n6",  1'b0, 1'b1, 2'd1, 1'b0);
            if (n == 12) chk_out("simul_gap.n12", 1'b0, 1'b1, 2'd0, 1'b0);
            if (n == 17) chk("simul_gap.n17.busy", bus.busy, 1'b1);
            if (n == 18) chk_out("simul_gap.n18", 1'b1, 1'b0, 2'd0, 1'b0);
        end

        // p on the exit-to-IDLE edge starts one clock later.
        for (int n = 0; n <= 14; n++) begin
            cyc((n == 0 || n == 6), 1'b1);
            if (n == 6)  chk_out("simul_idle.n6",  1'b1, 1'b0, 2'd1, 1'b0);
            if (n == 7)  chk_out("simul_idle.n7",  1'b0, 1'b1, 2'd0, 1'b0);
            if (n == 10) chk("simul_idle.n10.k", bus.k_out, 1'b0);
            if (n == 11) chk_out("simul_idle.n11", 1'b1, 1'b1, 2'd0, 1'b0);
            if (n == 13) chk_out("simul_idle.n13", 1'b1, 1'b0, 2'd0, 1'b0);
        end

        // Reset mid-ACTIVE discards the queue.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk_out("rst_mid.before", 1'b0, 1'b1, 2'd2, 1'b0);
`else
        // Request during ACTIVE is dropped and flags ovf.
        for (int n = 0; n <= 9; n++) begin
            cyc((n == 0 || n == 2), 1'b1);
            if (n == 2) chk_out("drop.n2", 1'b0, 1'b1, 2'd0, 1'b1);
            if (n == 6) chk_out("drop.n6", 1'b1, 1'b0, 2'd0, 1'b1);
            if (n == 9) chk_out("drop.n9", 1'b1, 1'b0, 2'd0, 1'b1);
        end
        do_reset();
        chk("drop.ovf_cleared", bus.ovf, 1'b0);

        // Request on the gap exit edge is dropped, not replayed.
        for (int n = 0; n <= 9; n++) begin
            cyc((n == 0 || n == 6), 1'b1);
            if (n == 5) chk_out("exit_drop.n5", 1'b1, 1'b1, 2'd0, 1'b0);
            if (n == 6) chk_out("exit_drop.n6", 1'b1, 1'b0, 2'd0, 1'b1);
            if (n == 7) chk_out("exit_drop.n7", 1'b1, 1'b0, 2'd0, 1'b1);
        end
        do_reset();

        // Reset mid-ACTIVE after a dropped request.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk_out("rst_mid.before", 1'b0, 1'b1, 2'd0, 1'b1);
`endif
        do_reset();
        chk_out("rst_mid.after", 1'b1, 1'b0, 2'd0, 1'b0);
        chk("rst_mid.state", bus.dbg_state, 2'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_out("rst_mid.no_replay", 1'b1, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 1'b1);
        chk_out("rst_mid.fresh", 1'b0, 1'b1, 2'd0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        chk("rst_mid.fresh_low4", bus.k_out, 1'b0);
        cyc(1'b0, 1'b1);
        chk_out("rst_mid.fresh_gap", 1'b1, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_out("rst_mid.fresh_idle", 1'b1, 1'b0, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
